// File: rtl/pi_digit_reader.sv
// Streams a snapshot of the multi-limb pi accumulator as decimal character codes.
// Optional build macro PI_INT_ZERO_SUPPRESS_EN suppresses leading zeros of the integer limb.
module pi_digit_reader #(
  parameter int L = 10,
  parameter int N = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [L*N-1:0] sum_in,
  output logic           busy,
  output logic           dout_valid,
  input  logic           dout_ready,
  output logic [3:0]     dout_code,
  output logic           dout_last,
  output logic           done,
  output logic           err
);

  localparam int IW = (L > 1) ? $clog2(L) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CONV  = 3'd1;
  localparam logic [2:0] S_EMIT  = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [IW-1:0] IDX_INT  = IW'(L - 1);
  localparam logic [IW-1:0] IDX_FRAC = IW'(L - 2);

`ifdef PI_INT_ZERO_SUPPRESS_EN
  localparam bit SUPPRESS = 1'b1;
`else
  localparam bit SUPPRESS = 1'b0;
`endif

  logic [2:0]     state_reg;
  logic [L*N-1:0] snap_reg;
  logic [IW-1:0]  idx_reg;
  logic           entry_reg;
  logic [9:0]     rem_reg;
  logic [3:0]     h_reg;
  logic [3:0]     t_reg;
  logic [3:0]     o_reg;
  logic [1:0]     pos_reg;
  logic           busy_reg;
  logic           dout_valid_reg;
  logic [3:0]     dout_code_reg;
  logic           dout_last_reg;
  logic           done_reg;
  logic           err_reg;

  logic [N-1:0] limb [L];
  logic [N-1:0] limb_sel;
  logic         limb_over;
  logic [9:0]   rem_load;
  logic [1:0]   first_pos;
  logic [3:0]   first_code;

  genvar gi;
  generate
    for (gi = 0; gi < L; gi++) begin : g_limb
      assign limb[gi] = snap_reg[N*gi +: N];
    end
  endgenerate

  // Out-of-range limbs are clamped so the digit counters never overflow.
  assign limb_sel  = limb[idx_reg];
  assign limb_over = 32'(limb_sel) > 32'd999;
  assign rem_load  = limb_over ? 10'd999 : 10'(limb_sel);

  // First digit position of a limb: skips leading zeros only on the integer limb when enabled.
  always_comb begin
    first_pos = 2'd0;
    if (SUPPRESS && (idx_reg == IDX_INT)) begin
      if (h_reg != 4'd0) begin
        first_pos = 2'd0;
      end else if (t_reg != 4'd0) begin
        first_pos = 2'd1;
      end else begin
        first_pos = 2'd2;
      end
    end
    case (first_pos)
      2'd0:    first_code = h_reg;
      2'd1:    first_code = t_reg;
      default: first_code = rem_reg[3:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      snap_reg       <= '0;
      idx_reg        <= '0;
      entry_reg      <= 1'b0;
      rem_reg        <= '0;
      h_reg          <= '0;
      t_reg          <= '0;
      o_reg          <= '0;
      pos_reg        <= '0;
      busy_reg       <= 1'b0;
      dout_valid_reg <= 1'b0;
      dout_code_reg  <= '0;
      dout_last_reg  <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            snap_reg  <= sum_in;
            idx_reg   <= IDX_INT;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b1;
            entry_reg <= 1'b1;
            state_reg <= S_CONV;
          end
        end
        S_CONV: begin
          if (entry_reg) begin
            entry_reg <= 1'b0;
            rem_reg   <= rem_load;
            h_reg     <= '0;
            t_reg     <= '0;
            o_reg     <= '0;
            if (limb_over) begin
              err_reg <= 1'b1;
            end
          end else if (rem_reg >= 10'd100) begin
            rem_reg <= rem_reg - 10'd100;
            h_reg   <= h_reg + 4'd1;
          end else if (rem_reg >= 10'd10) begin
            rem_reg <= rem_reg - 10'd10;
            t_reg   <= t_reg + 4'd1;
          end else begin
            // First beat is registered here so it is valid on EMIT entry.
            o_reg          <= rem_reg[3:0];
            pos_reg        <= first_pos;
            dout_code_reg  <= first_code;
            dout_last_reg  <= (idx_reg == '0) && (first_pos == 2'd2);
            dout_valid_reg <= 1'b1;
            state_reg      <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (dout_ready) begin
            if (pos_reg != 2'd2) begin
              pos_reg       <= pos_reg + 2'd1;
              dout_code_reg <= (pos_reg == 2'd0) ? t_reg : o_reg;
              dout_last_reg <= (idx_reg == '0) && (pos_reg == 2'd1);
            end else begin
              dout_last_reg <= 1'b0;
              if (idx_reg == IDX_INT) begin
                dout_code_reg <= 4'hA;
                state_reg     <= S_POINT;
              end else if (idx_reg != '0) begin
                dout_valid_reg <= 1'b0;
                idx_reg        <= idx_reg - IW'(1);
                entry_reg      <= 1'b1;
                state_reg      <= S_CONV;
              end else begin
                dout_valid_reg <= 1'b0;
                busy_reg       <= 1'b0;
                done_reg       <= 1'b1;
                state_reg      <= S_FIN;
              end
            end
          end
        end
        S_POINT: begin
          if (dout_ready) begin
            dout_valid_reg <= 1'b0;
            idx_reg        <= IDX_FRAC;
            entry_reg      <= 1'b1;
            state_reg      <= S_CONV;
          end
        end
        S_FIN: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_reg;
  assign dout_valid = dout_valid_reg;
  assign dout_code  = dout_code_reg;
  assign dout_last  = dout_last_reg;
  assign done       = done_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_pi_digit_reader.sv
// Scoreboard bench for pi_digit_reader: directed limb vectors, expected streams queued at start,
// a negedge monitor pops and compares every accepted beat and checks stall stability.
module tb_pi_digit_reader;
  localparam int L = 10;
  localparam int N = 10;

  typedef struct {
    logic [3:0] code;
    logic       last;
  } beat_t;

  logic           clk;
  logic           rst;
  logic           start;
  logic [L*N-1:0] sum_in;
  logic           busy;
  logic           dout_valid;
  logic           dout_ready;
  logic [3:0]     dout_code;
  logic           dout_last;
  logic           done;
  logic           err;

  pi_digit_reader #(.L(L), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sum_in     (sum_in),
    .busy       (busy),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_code  (dout_code),
    .dout_last  (dout_last),
    .done       (done),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int    tests = 0;
  int    fails = 0;
  int    beats = 0;
  int    done_cnt = 0;
  beat_t exp_q[$];

  logic       stall_prev = 1'b0;
  logic       last_acc_prev = 1'b0;
  logic [3:0] prev_code = '0;
  logic       prev_last = 1'b0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: samples mid-cycle, so inputs and outputs are stable for the next rising edge.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_prev    = 1'b0;
        last_acc_prev = 1'b0;
      end else begin
        if (last_acc_prev) begin
          check("done_after_last", int'(done), 1);
          check("busy_after_last", int'(busy), 0);
        end
        if (done) done_cnt++;
        if (stall_prev) begin
          tests++;
          if (dout_valid !== 1'b1 || dout_code !== prev_code || dout_last !== prev_last) begin
            fails++;
            $display("FAIL stall_hold: valid=%0b code=%0h last=%0b, required valid=1 code=%0h last=%0b",
                     dout_valid, dout_code, dout_last, prev_code, prev_last);
          end
        end
        last_acc_prev = 1'b0;
        if (dout_valid && dout_ready) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_beat: code=%0h last=%0b, required no beat", dout_code, dout_last);
          end else begin
            e = exp_q.pop_front();
            if (dout_code !== e.code || dout_last !== e.last) begin
              fails++;
              $display("FAIL beat_%0d: code=%0h last=%0b, required code=%0h last=%0b",
                       beats, dout_code, dout_last, e.code, e.last);
            end
          end
          beats++;
          last_acc_prev = dout_last;
        end
        stall_prev = dout_valid && !dout_ready;
        prev_code  = dout_code;
        prev_last  = dout_last;
      end
    end
  end

  task automatic push_str(input string s);
    beat_t b;
    byte   c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      b.code = (c == "A") ? 4'hA : 4'(c - 8'd48);
      b.last = (i == s.len() - 1);
      exp_q.push_back(b);
    end
  endtask

  function automatic logic [L*N-1:0] pack(input int v[L]);
    logic [L*N-1:0] r;
    r = '0;
    for (int i = 0; i < L; i++) r[N*i +: N] = N'(v[i]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One read: queue expected beats, accept start, then drive ready until done or budget runs out.
  task automatic run_stream(input string name, input logic [L*N-1:0] vec, input string s,
                            input bit rand_ready, input int start_beat, input int exp_err);
    int lat;
    int cyc;
    bit pulsed;
    push_str(s);
    beats    = 0;
    done_cnt = 0;
    pulsed   = 1'b0;
    sum_in   = vec;
    start    = 1'b1;
    tick();
    start  = 1'b0;
    sum_in = '1;
    check({name, "_busy_on_accept"}, int'(busy), 1);
    check({name, "_err_cleared"}, int'(err), 0);
    lat = 0;
    while (!dout_valid && lat < 40) begin
      dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      lat++;
    end
    check({name, "_first_valid_latency"}, lat, 2);
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (start_beat > 0 && beats >= start_beat && !pulsed) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 3000) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: no done after %0d cycles, required done", name, cyc);
    end
    tick();
    tick();
    check({name, "_beat_count"}, beats, s.len());
    check({name, "_leftover"}, exp_q.size(), 0);
    check({name, "_done_pulses"}, done_cnt, 1);
    check({name, "_err"}, int'(err), exp_err);
    check({name, "_busy_idle"}, int'(busy), 0);
    exp_q.delete();
    $display("[TB] read %s: %0d beats", name, beats);
  endtask

  initial begin
    int main_limbs[L] = '{383, 643, 462, 238, 793, 589, 653, 592, 141, 3};
    int err_limbs[L]  = '{0, 0, 0, 0, 0, 0, 0, 1023, 7, 0};
    string int3, int0, s_main, s_err;
    int wait_cyc;

`ifdef PI_INT_ZERO_SUPPRESS_EN
    int3 = "3";
    int0 = "0";
`else
    int3 = "003";
    int0 = "000";
`endif
    s_main = {int3, "A141592653589793238462643383"};
    s_err  = {int0, "A007999"};
    for (int i = 0; i < 7; i++) s_err = {s_err, "000"};

    rst        = 1'b0;
    start      = 1'b0;
    sum_in     = '0;
    dout_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(dout_valid), 0);
    check("rst_code", int'(dout_code), 0);
    check("rst_last", int'(dout_last), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b1;
    tick();

    run_stream("main", pack(main_limbs), s_main, 1'b0, 0, 0);
    run_stream("main_stall", pack(main_limbs), s_main, 1'b1, 0, 0);
    run_stream("clamp", pack(err_limbs), s_err, 1'b0, 0, 1);
    tick();
    check("err_sticky_idle", int'(err), 1);
    run_stream("restart_busy", pack(main_limbs), s_main, 1'b1, 5, 0);

    // Abort mid-stream, then a fresh read must reproduce the whole stream.
    push_str(s_main);
    beats      = 0;
    sum_in     = pack(main_limbs);
    start      = 1'b1;
    tick();
    start      = 1'b0;
    dout_ready = 1'b1;
    wait_cyc   = 0;
    while (beats < 10 && wait_cyc < 500) begin
      tick();
      wait_cyc++;
    end
    check("abort_reached_beat10", beats, 10);
    rst = 1'b0;
    #1;
    check("abort_valid", int'(dout_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_last", int'(dout_last), 0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b1;
    tick();
    run_stream("after_abort", pack(main_limbs), s_main, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pi_digit_reader.md
Name: pi_digit_reader

Overview:
- Reader side of the multi-limb pi accumulator. The accumulator (the writer) produces a packed vector of L limbs, each N bits wide.
- Each limb holds one base-1000 digit group (0..999). Limb L-1 is the integer part; limbs L-2..0 are the fractional groups, most significant first.
- On start, the block snapshots the vector and converts each limb to decimal digits sequentially. It streams one character code per beat over a valid/ready handshake to the VGA text renderer.

Parameters:
- L, 10, number of limbs, integer limb included.
- N, 10, bits per limb.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to read sum_in; ignored while busy=1.
- sum_in  in  L*N  packed limbs; limb i = sum_in[N*i +: N].
- busy  out  1  high from the start-accept cycle until the last beat is accepted.
- dout_valid  out  1  dout_code/dout_last are valid.
- dout_ready  in  1  consumer accepts the beat when valid&&ready.
- dout_code  out  4  0..9 = decimal digit, 4'hA = decimal point; other codes never produced.
- dout_last  out  1  marks the final digit of limb 0.
- done  out  1  one-cycle pulse in the cycle after the last beat is accepted.
- err  out  1  sticky: some limb exceeded 999 in the current read; cleared on start accept.

Behaviour:
- Reset (async, rst=0) forces: state IDLE, busy=0, dout_valid=0, dout_code=0, dout_last=0, done=0, err=0, snapshot register=0, all counters=0. Reset mid-stream aborts immediately; no partial beat survives.
- States: IDLE, CONV, EMIT, POINT, FIN.
- IDLE: when start=1, latch sum_in into the snapshot. Set limb index idx=L-1, clear err, busy=1, go to CONV.
  - The writer may modify sum_in afterwards; only the snapshot is read.
- CONV, entry cycle: load rem = limb[idx]. If the limb value is >999, load 999 and set err.
- CONV, each following cycle (hundreds h, tens t, ones o counters):
  - if rem>=100: rem-=100, h++;
  - else if rem>=10: rem-=10, t++;
  - else: o=rem, go to EMIT.
  - Worst case (999) is 1+9+9+1 = 20 cycles.
- EMIT: present digits h, t, o in order, one per accepted beat.
  - Integer limb (idx=L-1) with the optional feature enabled: leading zeros are suppressed. At least one digit (the ones digit) is always sent.
  - Fractional limbs: always exactly 3 digits, zero-padded.
  - After the last digit of limb L-1, go to POINT.
  - After the last digit of any other limb with idx>0: idx--, go to CONV.
  - After the last digit of limb 0: go to FIN.
- POINT: present code 4'hA for one beat. On acceptance: idx=L-2, go to CONV.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- Handshake rules:
  - dout_valid rises only in EMIT/POINT.
  - While valid && !ready, dout_code and dout_last hold stable and valid stays high.
  - Back-to-back beats within one limb need no bubble.
  - Between limbs there is a conversion gap (dout_valid=0) of 2..20 cycles.
- dout_last=1 only on the ones digit of limb 0.
- Beat count per read: 3*(L-1) fractional beats + 1 point beat + 1..3 integer beats.
- start while busy=1 is ignored: no restart, no error.
- start in the same cycle as FIN is ignored; it is accepted from IDLE on the next cycle.
- Latency: start accepted at cycle T gives the first dout_valid at T+2 for an integer limb value <10.

Optional Feature:
- Macro: PI_INT_ZERO_SUPPRESS_EN.
- Defined: leading zeros of the integer limb are suppressed. Integer value 3 gives a single beat "3"; value 0 gives a single beat "0".
- Not defined: the integer limb is emitted as 3 digits like fractional limbs ("003"), a fixed 3*L+1 beats per read.

Test Plan:
- Feature on, limbs L-1..0 = 3,141,592,653,589,793,238,462,643,383, dout_ready=1 -> 29 beats: 3,A,1,4,1,5,9,2,6,5,3,5,8,9,7,9,3,2,3,8,4,6,2,6,4,3,3,8,3. dout_last on the final 3; done one cycle later; err=0.
- Same input, dout_ready toggled pseudo-randomly -> identical sequence, and code/last stable on every stalled cycle.
- Fractional limb = 7, another = 1023 -> beats "0,0,7" and "9,9,9"; err=1 until the next start is accepted.
- Feature off, integer limb 3 -> stream begins 0,0,3,A and totals 31 beats.
- start pulsed at beat 5 while busy -> stream unaffected; a single done pulse.
- rst=0 at beat 10 -> dout_valid=0 and busy=0 immediately. A new start after release reproduces the full 29-beat stream from the first beat.
